vlog_statmchs_sum_collect: RTL and testbench

Downstream stage of the three-sample summing state machine. Detects each completed result by the rising edge of that machine's `ready`, captures the 8-bit `sum` into a small FIFO, and presents results to a consumer over a valid/ack handshake. Counts results lost to a full FIFO, with an optional running-peak tracker.

---
 rtl/vlog_statmchs_pkg.sv | 11 +
 rtl/vlog_statmchs_sum_fifo.sv | 82 ++++++++
 rtl/vlog_statmchs_sum_collect.sv | 112 +++++++++++
 tb/tb_vlog_statmchs_sum_collect.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vlog_statmchs_pkg.sv
// Shared widths and types for the summing state machine and its result collector.
package vlog_statmchs_pkg;

  localparam int unsigned SUM_W              = 8;
  localparam int unsigned SUM_FIFO_DEPTH_DEF = 4;

  typedef logic [SUM_W-1:0] sum_t;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

endpackage : vlog_statmchs_pkg

// File: rtl/vlog_statmchs_sum_fifo.sv
// Small show-ahead FIFO holding collected sums: storage, pointers and occupancy.
// Pop is ignored when empty; push while full is only taken if a pop happens too.
module vlog_statmchs_sum_fifo
  import vlog_statmchs_pkg::*;
#(
  parameter int unsigned  W     = SUM_W,
  parameter int unsigned  DEPTH = SUM_FIFO_DEPTH_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] fill,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             push_en_c;
  logic             pop_en_c;

  assign full  = (fill_q == CNT_W'(DEPTH));
  assign empty = (fill_q == '0);
  assign fill  = fill_q;
  assign rdata = mem_q[rd_ptr_q];

  assign pop_en_c  = pop & ~empty;
  assign push_en_c = push & (~full | pop_en_c);

  // Next pointer and occupancy values; flush overrides any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_en_c, pop_en_c})
        2'b10:   fill_d = fill_q + CNT_W'(1);
        2'b01:   fill_d = fill_q - CNT_W'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage; cleared on reset and flush so an empty FIFO presents zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_en_c) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule : vlog_statmchs_sum_fifo

// File: rtl/vlog_statmchs_sum_collect.sv
// Collects each sum from the upstream summer on the rising edge of its ready,
// buffers it for a valid/ack consumer and counts results lost to a full FIFO.
// Optional running-peak tracker enabled by defining SUM_COLLECT_PEAK_EN.
module vlog_statmchs_sum_collect
  import vlog_statmchs_pkg::*;
#(
  parameter int unsigned  W     = SUM_W,
  parameter int unsigned  DEPTH = SUM_FIFO_DEPTH_DEF,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             ready_in,
  input  logic [W-1:0]     sum_in,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] fill,
  output logic             overflow,
  output logic [7:0]       drop_cnt
`ifdef SUM_COLLECT_PEAK_EN
  ,
  output logic [W-1:0]     peak
`endif
);

  logic       ready_d_q;
  logic       capture_c;
  logic       pop_c;
  logic       push_c;
  logic       drop_c;
  logic       full_c;
  logic       empty_c;
  logic       overflow_q, overflow_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Edge history resets high so a ready held high out of reset never captures.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_d_q <= 1'b1;
    else          ready_d_q <= ready_in;
  end

  assign capture_c = ready_in & ~ready_d_q;
  assign out_valid = ~empty_c;
  assign pop_c     = out_valid & out_ack;
  assign push_c    = capture_c & ~clr & (~full_c | pop_c);
  assign drop_c    = capture_c & ~clr & full_c & ~pop_c;

  vlog_statmchs_sum_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (clr),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   (sum_in),
    .rdata   (out_data),
    .fill    (fill),
    .full    (full_c),
    .empty   (empty_c)
  );

  // Sticky overflow flag and saturating drop counter.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != DROP_CNT_MAX) drop_cnt_d = drop_cnt_q + 8'(1);
    end
  end

  // Drop statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

`ifdef SUM_COLLECT_PEAK_EN
  logic [W-1:0] peak_q, peak_d;

  // Running maximum of accepted values; dropped results never count.
  always_comb begin
    peak_d = peak_q;
    if (clr)                             peak_d = '0;
    else if (push_c && sum_in > peak_q)  peak_d = sum_in;
  end

  // Peak register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) peak_q <= '0;
    else          peak_q <= peak_d;
  end

  assign peak = peak_q;
`endif

endmodule : vlog_statmchs_sum_collect

// File: tb/tb_vlog_statmchs_sum_collect.sv
// Self-checking bench for vlog_statmchs_sum_collect: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
// Peak checks are compiled in when SUM_COLLECT_PEAK_EN is defined.
module tb_vlog_statmchs_sum_collect;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset_n;
  logic       clr;
  logic       ready_in;
  logic [7:0] sum_in;
  logic       out_valid;
  logic       out_ack;
  logic [7:0] out_data;
  logic [2:0] fill;
  logic       overflow;
  logic [7:0] drop_cnt;
`ifdef SUM_COLLECT_PEAK_EN
  logic [7:0] peak;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int q[$];
  int m_drop;
  bit m_ovf;
  int m_peak;
  bit m_prev;

  vlog_statmchs_sum_collect #(
    .W     (8),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .ready_in  (ready_in),
    .sum_in    (sum_in),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .out_data  (out_data),
    .fill      (fill),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
`ifdef SUM_COLLECT_PEAK_EN
    ,
    .peak      (peak)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("fill", 32'(fill), 32'(q.size()));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("out_data", 32'(out_data), 32'(q[0]));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`ifdef SUM_COLLECT_PEAK_EN
    check("peak", 32'(peak), 32'(m_peak));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0;
    m_ovf  = 1'b0;
    m_peak = 0;
    m_prev = 1'b1;
  endtask

  // What the collector should do at one rising edge, from the behavioural rules.
  task automatic model_edge(input bit r, input int s, input bit a, input bit c);
    bit cap;
    bit pop;
    bit was_full;
    cap      = r && !m_prev;
    pop      = a && (q.size() > 0);
    was_full = (q.size() == DEPTH);
    if (c) begin
      q.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
      m_peak = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (!was_full || pop) begin
          q.push_back(s);
          if (s > m_peak) m_peak = s;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    m_prev = r;
  endtask

  // Called at a falling edge: drive, clock, update model, check at next falling edge.
  task automatic step(input bit r, input logic [7:0] s, input bit a, input bit c);
    ready_in = r;
    sum_in   = s;
    out_ack  = a;
    clr      = c;
    @(posedge clk);
    model_edge(r, int'(s), a, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse(input logic [7:0] s, input bit a);
    step(1'b1, s, a, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain(input logic [7:0] exp);
    check("drain_data", 32'(out_data), 32'(exp));
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; effects must be immediate.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_out_data", 32'(out_data), 32'h0);
`ifdef SUM_COLLECT_PEAK_EN
    check("rst_peak", 32'(peak), 32'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    clk      = 1'b0;
    reset_n  = 1'b0;
    clr      = 1'b0;
    ready_in = 1'b1;
    sum_in   = 8'h00;
    out_ack  = 1'b0;
    model_reset();

    @(negedge clk);
    do_reset();

    // ready held high out of reset: nothing captured until it toggles
    repeat (3) step(1'b1, 8'hAB, 1'b0, 1'b0);
    check("hold_no_capture", 32'(fill), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hAB, 1'b0, 1'b0);
    check("toggle_capture", 32'(fill), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // two results, no ack, then drain
    pulse(8'h12, 1'b0);
    check("two_fill1", 32'(fill), 32'h1);
    pulse(8'h34, 1'b0);
    check("two_fill2", 32'(fill), 32'h2);
    check("two_head", 32'(out_data), 32'h12);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("two_next", 32'(out_data), 32'h34);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("two_empty", 32'(out_valid), 32'h0);

    // overflow: fifth result dropped, contents intact
    for (int i = 1; i <= 4; i++) pulse(8'(i), 1'b0);
    pulse(8'h55, 1'b0);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_cnt", 32'(drop_cnt), 32'h1);
    for (int i = 1; i <= 4; i++) drain(8'(i));
    check("ovf_drained", 32'(out_valid), 32'h0);

    // full FIFO with a capture coinciding with an ack
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) pulse(8'(i), 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("coinc_fill", 32'(fill), 32'h4);
    check("coinc_drop", 32'(drop_cnt), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain(8'h02);
    drain(8'h03);
    drain(8'h04);
    drain(8'h77);

    // drop counter saturation, then flush
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 260; i++) pulse(8'($urandom), 1'b0);
    check("sat_cnt", 32'(drop_cnt), 32'hFF);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_cnt", 32'(drop_cnt), 32'h0);
    check("clr_ovf", 32'(overflow), 32'h0);
    check("clr_fill", 32'(fill), 32'h0);

    // peak tracking and mid-stream reset
    pulse(8'h10, 1'b0);
    pulse(8'hF0, 1'b0);
    pulse(8'h20, 1'b0);
`ifdef SUM_COLLECT_PEAK_EN
    check("peak_max", 32'(peak), 32'hF0);
`endif
    step(1'b1, 8'h99, 1'b0, 1'b0);
    do_reset();
    check("midrst_fill", 32'(fill), 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), 8'($urandom),
             1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 149) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_vlog_statmchs_sum_collect
